// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared widths, FSM encoding and saturation limits for the NPU core
package npu_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 26;

   localparam int SAT_HI = (2 ** (DEF_DATA_W - 1)) - 1;
   localparam int SAT_LO = -(2 ** (DEF_DATA_W - 1));

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/npu_mac.sv
// rtl/npu_mac.sv - 3-stage multiply / accumulate / shift-saturate pipeline
module npu_mac
   import npu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_x,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic              in_last,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        oshift,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_HI);
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_LO);

   logic signed [2*DATA_W-1:0] prod;
   logic                       s1_valid;
   logic                       s1_first;
   logic                       s1_last;
   logic signed [ACC_W-1:0]    acc;
   logic                       s2_last;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    shifted;
   logic [DATA_W-1:0]          sat;

   assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign shifted  = acc >>> oshift;

   always_comb begin
      sat = shifted[DATA_W-1:0];
      if (shifted > HI)
         sat = HI[DATA_W-1:0];
      else if (shifted < LO)
         sat = LO[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         prod      <= '0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         acc       <= '0;
         s2_last   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_first <= in_valid & in_first;
         s1_last  <= in_valid & in_last;
         if (in_valid)
            prod <= $signed(a) * $signed(b);

         // a first-tagged product restarts the sum so groups can run back to back
         if (s1_valid)
            acc <= s1_first ? prod_ext : acc + prod_ext;
         s2_last <= s1_valid & s1_last;

         out_valid <= s2_last;
         if (s2_last)
            out_data <= sat;
      end
   end

endmodule

// File: rtl/npu_core.sv
// rtl/npu_core.sv - job FSM and pair/output counters driving the MAC pipeline
module npu_core
   import npu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              CLK,
   input  logic              RESET_X,
   input  logic              SOFT_RESET,
   input  logic              START,
   input  logic [9:0]        KLEN,
   input  logic [9:0]        NOUT,
   input  logic [3:0]        OSHIFT,
   input  logic              NPU_EN,
   input  logic [DATA_W-1:0] A_RDATA,
   input  logic [DATA_W-1:0] B_RDATA,
   output logic              LM_EN,
   output logic [DATA_W-1:0] C_WDATA,
   output logic              BUSY,
   output logic              FINISH
);

   logic       rst_x;
   state_t     state;
   logic [9:0] klen_l;
   logic [9:0] nout_l;
   logic [3:0] oshift_l;
   logic [9:0] kcnt;
   logic [9:0] ncnt;
   logic       pair_in;
   logic       pair_last;

   assign rst_x     = RESET_X & SOFT_RESET;
   assign pair_in   = (state == ST_RUN) & NPU_EN;
   assign pair_last = (kcnt == klen_l - 10'd1);

   always_ff @(posedge CLK or negedge rst_x) begin
      if (!rst_x) begin
         state    <= ST_IDLE;
         klen_l   <= '0;
         nout_l   <= '0;
         oshift_l <= '0;
         kcnt     <= '0;
         ncnt     <= '0;
         BUSY     <= 1'b0;
         FINISH   <= 1'b0;
      end else begin
         FINISH <= 1'b0;
         case (state)
            ST_IDLE: if (START) begin
               klen_l   <= (KLEN == 10'd0) ? 10'd1 : KLEN;
               nout_l   <= NOUT;
               oshift_l <= OSHIFT;
               kcnt     <= '0;
               ncnt     <= '0;
               BUSY     <= 1'b1;
               state    <= (NOUT == 10'd0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: if (NPU_EN) begin
               if (pair_last) begin
                  kcnt <= '0;
                  ncnt <= ncnt + 10'd1;
                  if (ncnt == nout_l - 10'd1)
                     state <= ST_FLUSH;
               end else begin
                  kcnt <= kcnt + 10'd1;
               end
            end
            // kcnt is idle here, so it times the two cycles until the final result lands
            ST_FLUSH: begin
               if (kcnt == 10'd1) begin
                  kcnt  <= '0;
                  state <= ST_DONE;
               end else begin
                  kcnt <= kcnt + 10'd1;
               end
            end
            ST_DONE: begin
               FINISH <= 1'b1;
               BUSY   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   npu_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk       (CLK),
      .rst_x     (rst_x),
      .in_valid  (pair_in),
      .in_first  (kcnt == 10'd0),
      .in_last   (pair_last),
      .a         (A_RDATA),
      .b         (B_RDATA),
      .oshift    (oshift_l),
      .out_valid (LM_EN),
      .out_data  (C_WDATA)
   );

endmodule

// File: tb/tb_npu_core.sv
// tb/tb_npu_core.sv - randomized self-checking bench for npu_core against a behavioural model
module tb_npu_core;

   logic       CLK = 1'b0;
   logic       RESET_X;
   logic       SOFT_RESET;
   logic       START;
   logic [9:0] KLEN;
   logic [9:0] NOUT;
   logic [3:0] OSHIFT;
   logic       NPU_EN;
   logic [7:0] A_RDATA;
   logic [7:0] B_RDATA;
   logic       LM_EN;
   logic [7:0] C_WDATA;
   logic       BUSY;
   logic       FINISH;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int got_v[$];
   int got_c[$];
   int fin_count = 0;
   int fin_cyc = 0;
   int pa[$];
   int pb[$];

   npu_core dut (
      .CLK        (CLK),
      .RESET_X    (RESET_X),
      .SOFT_RESET (SOFT_RESET),
      .START      (START),
      .KLEN       (KLEN),
      .NOUT       (NOUT),
      .OSHIFT     (OSHIFT),
      .NPU_EN     (NPU_EN),
      .A_RDATA    (A_RDATA),
      .B_RDATA    (B_RDATA),
      .LM_EN      (LM_EN),
      .C_WDATA    (C_WDATA),
      .BUSY       (BUSY),
      .FINISH     (FINISH)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (LM_EN) begin
         got_v.push_back(int'($signed(C_WDATA)));
         got_c.push_back(cyc);
      end
      if (FINISH) begin
         fin_count++;
         fin_cyc = cyc;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model_out(input int sum, input int osh);
      int r;
      r = sum >>> osh;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic fill_const(input int n, input int a, input int b);
      pa.delete();
      pb.delete();
      for (int i = 0; i < n; i++) begin
         pa.push_back(a);
         pb.push_back(b);
      end
   endtask

   task automatic fill_rand(input int n);
      pa.delete();
      pb.delete();
      for (int i = 0; i < n; i++) begin
         pa.push_back(int'($urandom_range(255)) - 128);
         pb.push_back(int'($urandom_range(255)) - 128);
      end
   endtask

   task automatic run_job(input string name, input int klen, input int nout, input int osh,
                          input int gap_pct, input bit stray_start);
      int keff;
      int exp_v[$];
      int last_cyc[$];
      int c0;
      int idx;
      int sum;
      keff = (klen == 0) ? 1 : klen;
      for (int g = 0; g < nout; g++) begin
         sum = 0;
         for (int k = 0; k < keff; k++)
            sum += pa[g*keff + k] * pb[g*keff + k];
         exp_v.push_back(model_out(sum, osh));
      end
      got_v.delete();
      got_c.delete();
      fin_count = 0;

      @(posedge CLK); #1;
      START  = 1'b1;
      KLEN   = 10'(klen);
      NOUT   = 10'(nout);
      OSHIFT = 4'(osh);
      c0 = cyc;
      @(posedge CLK); #1;
      START  = 1'b0;
      KLEN   = 10'($urandom);
      NOUT   = 10'($urandom);
      OSHIFT = 4'($urandom);
      check({name, " busy"}, int'(BUSY), 1);

      idx = 0;
      while (idx < keff * nout) begin
         START = stray_start && ($urandom_range(7) == 0);
         if (int'($urandom_range(99)) < gap_pct) begin
            NPU_EN  = 1'b0;
            A_RDATA = 8'($urandom);
            B_RDATA = 8'($urandom);
         end else begin
            NPU_EN  = 1'b1;
            A_RDATA = 8'(pa[idx]);
            B_RDATA = 8'(pb[idx]);
            if ((idx % keff) == keff - 1) last_cyc.push_back(cyc);
            idx++;
         end
         @(posedge CLK); #1;
      end
      START = 1'b0;
      for (int i = 0; i < 100 && fin_count == 0; i++) begin
         NPU_EN  = 1'($urandom);
         A_RDATA = 8'($urandom);
         B_RDATA = 8'($urandom);
         @(posedge CLK); #1;
      end
      NPU_EN = 1'b0;
      repeat (4) @(posedge CLK);
      #1;

      check({name, " finish_count"}, fin_count, 1);
      check({name, " lm_en_count"}, got_v.size(), nout);
      for (int i = 0; i < nout && i < got_v.size(); i++) begin
         check($sformatf("%s value[%0d]", name, i), got_v[i], exp_v[i]);
         check($sformatf("%s latency[%0d]", name, i), got_c[i] - last_cyc[i], 3);
      end
      if (nout == 0)
         check({name, " finish_cycle"}, fin_cyc - c0, 2);
      else if (got_c.size() == nout)
         check({name, " finish_cycle"}, fin_cyc - got_c[nout-1], 1);
      check({name, " busy_after"}, int'(BUSY), 0);
   endtask

   initial begin
      RESET_X    = 1'b0;
      SOFT_RESET = 1'b1;
      START      = 1'b0;
      KLEN       = '0;
      NOUT       = '0;
      OSHIFT     = '0;
      NPU_EN     = 1'b0;
      A_RDATA    = '0;
      B_RDATA    = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset lm_en", int'(LM_EN), 0);
      check("reset c_wdata", int'(C_WDATA), 0);
      check("reset busy", int'(BUSY), 0);
      check("reset finish", int'(FINISH), 0);
      RESET_X = 1'b1;

      pa = '{1, 2, 3, 4};
      pb = '{1, 1, 1, 1};
      run_job("sum10", 4, 1, 0, 0, 1'b0);

      fill_const(2, 127, 127);
      run_job("sat_hi", 2, 1, 0, 0, 1'b0);
      fill_const(2, -128, 127);
      run_job("sat_lo", 2, 1, 0, 0, 1'b0);
      fill_const(1, 100, 100);
      run_job("shift7", 1, 1, 7, 0, 1'b0);
      fill_const(1, 9, 9);
      run_job("klen0", 0, 1, 0, 0, 1'b0);

      fill_const(6, 1, 2);
      run_job("cont3", 2, 3, 0, 0, 1'b0);
      fill_const(6, 1, 2);
      run_job("gaps3", 2, 3, 0, 40, 1'b1);

      run_job("nout0", 3, 0, 0, 0, 1'b0);

      // abort mid-job with a one-cycle soft reset
      fill_const(8, 5, 6);
      got_v.delete();
      fin_count = 0;
      @(posedge CLK); #1;
      START = 1'b1; KLEN = 10'd4; NOUT = 10'd2; OSHIFT = 4'd0;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int i = 0; i < 6; i++) begin
         NPU_EN = 1'b1; A_RDATA = 8'd5; B_RDATA = 8'd6;
         @(posedge CLK); #1;
      end
      SOFT_RESET = 1'b0;
      NPU_EN = 1'b0;
      #1;
      check("soft lm_en", int'(LM_EN), 0);
      check("soft c_wdata", int'(C_WDATA), 0);
      check("soft busy", int'(BUSY), 0);
      check("soft finish", int'(FINISH), 0);
      @(posedge CLK); #1;
      SOFT_RESET = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("soft no_lm_en", got_v.size(), 0);
      check("soft no_finish", fin_count, 0);
      fill_const(1, 3, 5);
      run_job("after_soft", 1, 1, 0, 0, 1'b0);

      for (int j = 0; j < 20; j++) begin
         int kl;
         int no;
         kl = int'($urandom_range(6));
         no = int'($urandom_range(4));
         fill_rand(((kl == 0) ? 1 : kl) * no);
         run_job($sformatf("rand%0d", j), kl, no, int'($urandom_range(15)),
                 int'($urandom_range(50)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/npu_core.md
NPU_CORE -- requirements
Module: npu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand and result width (signed two's complement).
REQ-002 SHALL have parameter ACC_W, default 26, accumulator width (holds 1023 x 16384 signed without overflow).
REQ-003 SHALL have ports: CLK  in  1  single clock, all logic rising-edge.
REQ-004 RESET_X  in  1  asynchronous active-low reset.
REQ-005 SOFT_RESET  in  1  active-low; ANDed with RESET_X to form the internal asynchronous reset rst_x.
REQ-006 START  in  1  one-cycle job start pulse from CPU.
REQ-007 KLEN  in  10  operand pairs per output.
REQ-008 NOUT  in  10  outputs per job.
REQ-009 OSHIFT  in  4  arithmetic right shift applied before saturation.
REQ-010 NPU_EN  in  1  A_RDATA/B_RDATA valid this cycle (from local memory controller).
REQ-011 A_RDATA  in  DATA_W  operand A; B_RDATA  in  DATA_W  operand B.
REQ-012 LM_EN  out  1  C_WDATA valid strobe to local memory controller.
REQ-013 C_WDATA  out  DATA_W  result byte.
REQ-014 BUSY  out  1  high from accepted START until FINISH; FINISH  out  1  one-cycle job-done pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-016 IDLE: START=1 latches KLEN, NOUT, OSHIFT, clears counters, enters RUN; if NOUT=0, enters DONE instead.
REQ-017 KLEN=0 SHALL be treated as 1.
REQ-018 START outside IDLE SHALL be ignored; config changes after START SHALL have no effect on the running job.
REQ-019 RUN: each cycle with NPU_EN=1 accepts one pair; NPU_EN=0 stalls counting, no pipeline bubble penalty beyond the missing pair.
REQ-020 Pair counter kcnt 0..KLEN-1 wraps on the last pair of a group; output counter ncnt increments on each wrap.
REQ-021 Last pair of group NOUT-1 accepted -> FLUSH; NPU_EN ignored in FLUSH, DONE, IDLE.
REQ-022 Pipeline stage 1: signed product A x B registered (2*DATA_W bits) with first/last tags.
REQ-023 Stage 2: tagged-first product loads accumulator; otherwise adds; no carry-over between groups, back-to-back groups at full rate.
REQ-024 Stage 3: on tagged-last, result = acc >>> OSHIFT, clamped to [-128, 127], registered to C_WDATA with LM_EN=1 for one cycle.
REQ-025 Latency: last pair of a group at cycle t -> LM_EN=1 at cycle t+3.
REQ-026 FLUSH exits to DONE the cycle after the final LM_EN; DONE asserts FINISH=1 for exactly one cycle, then IDLE.
REQ-027 C_WDATA SHALL hold its last value when LM_EN=0.

Reset
REQ-028 rst_x low SHALL force: state IDLE, counters 0, accumulator 0, pipeline valid/tags 0, LM_EN=0, C_WDATA=0, BUSY=0, FINISH=0.
REQ-029 SOFT_RESET low mid-RUN SHALL abort the job with no LM_EN or FINISH emitted; next START after release SHALL run normally.

Structure
REQ-030 Package npu_pkg SHALL hold DATA_W/ACC_W defaults, FSM state encoding, saturation limits.
REQ-031 Sub-module npu_mac SHALL contain the 3-stage multiply/accumulate/shift-saturate pipeline; npu_core holds FSM and counters.

Verification
REQ-032 KLEN=4, NOUT=1, OSHIFT=0, A={1,2,3,4}, B={1,1,1,1} -> single LM_EN with C_WDATA=10 three cycles after last pair; FINISH next cycle.
REQ-033 KLEN=2, A={127,127}, B={127,127} -> C_WDATA=127 (saturated); A={-128,-128}, B={127,127} -> C_WDATA=-128 (0x80).
REQ-034 KLEN=1, OSHIFT=7, A=100, B=100 -> C_WDATA=78.
REQ-035 KLEN=2, NOUT=3, NPU_EN continuous then with random gaps, all pairs A=1,B=2 -> exactly 3 LM_EN pulses, each C_WDATA=4.
REQ-036 SOFT_RESET low for 1 cycle mid-RUN -> all outputs 0, no FINISH; following job KLEN=1 A=3 B=5 -> C_WDATA=15.
REQ-037 NOUT=0 -> FINISH exactly 2 cycles after START, no LM_EN; START during BUSY -> ignored.
